// File: rtl/random_range_gen_if.sv
// Handshake bundle for random_range_gen: reseed strobe/value from the
// consumer side, valid/data toward it, and the consumer's ready.
interface random_range_gen_if #(
  parameter int                width_p = 16,
  parameter longint unsigned   range_p = 7
);
  localparam int out_width_p = $clog2(range_p);

  logic                   seed_v_i;
  logic [width_p-1:0]     seed_i;
  logic                   ready_i;
  logic                   v_o;
  logic [out_width_p-1:0] data_o;

  // Consumer / environment side.
  modport master (
    output seed_v_i, seed_i, ready_i,
    input  v_o, data_o
  );

  // Generator side.
  modport slave (
    input  seed_v_i, seed_i, ready_i,
    output v_o, data_o
  );
endinterface

// File: rtl/random_range_gen.sv
// Uniform random values in 0..range_p-1 from a free-running Galois LFSR,
// using rejection sampling on the low out_width_p state bits and a
// one-entry valid/ready output register.
// Optional feature macro: RANDOM_ZERO_RECOVER_EN -- replaces a zero reseed
// value and any all-zero LFSR state with seed_p.
module random_range_gen #(
  parameter int                width_p = 16,
  parameter logic [width_p-1:0] mask_p = width_p'(16'h002D),
  parameter logic [width_p-1:0] seed_p = width_p'(38),
  parameter longint unsigned   range_p = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  random_range_gen_if.slave  bus
);
  localparam int out_width_p = $clog2(range_p);
  // One extra bit so range_p = 2^out_width_p is representable.
  localparam logic [out_width_p:0] range_lp = (out_width_p + 1)'(range_p);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                 state_q, state_d;
  logic [width_p-1:0]     r_q, r_step, r_next, seed_load;
  logic [out_width_p-1:0] cand, data_q;
  logic                   accept, load;

  // One Galois step: the MSB feeds bit 0 and is XORed into every tapped bit
  // above it; mask bit 0 has no meaning and is ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    r_step    = '0;
    r_step[0] = r_q[width_p-1];
    for (int i = 1; i < width_p; i++) begin
      r_step[i] = r_q[i-1] ^ (mask_p[i] & r_q[width_p-1]);
    end
  end

`ifdef RANDOM_ZERO_RECOVER_EN
  // A zero state would lock the LFSR; fall back to the reset seed instead.
  assign seed_load = (bus.seed_i == '0) ? seed_p : bus.seed_i;
  assign r_next    = (r_q == '0) ? seed_p : r_step;
`else
  assign seed_load = bus.seed_i;
  assign r_next    = r_step;
`endif

  // Candidate is taken from the registered state, never from r_next.
  assign cand   = r_q[out_width_p-1:0];
  assign accept = ({1'b0, cand} < range_lp);

  // Output FSM next state: fill when empty, refill or drain on handshake.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.ready_i) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register, LFSR and output data: reset beats reseed beats step.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (reset_i) begin
      r_q     <= seed_p;
      state_q <= EMPTY;
      data_q  <= '0;
    end else if (bus.seed_v_i) begin
      // Reseed discards any pending value even if it was being accepted.
      r_q     <= seed_load;
      state_q <= EMPTY;
    end else begin
      r_q     <= r_next;
      state_q <= state_d;
      if (load) begin
        data_q <= cand;
      end
    end
  end

  assign bus.v_o    = (state_q == FULL);
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_random_range_gen.sv
// Self-checking bench for random_range_gen (default parameters). Honors
// RANDOM_ZERO_RECOVER_EN the same way the design does.
module tb_random_range_gen;
  localparam int          W     = 16;
  localparam logic [15:0] MASK  = 16'h002D;
  localparam logic [15:0] SEED  = 16'd38;
  localparam int          RANGE = 7;
`ifdef RANDOM_ZERO_RECOVER_EN
  localparam bit zr = 1'b1;
`else
  localparam bit zr = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  random_range_gen_if #(.width_p(W), .range_p(RANGE)) bus ();

  random_range_gen dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural reference: LFSR value, output register contents, validity.
  logic [15:0] m_r;
  logic [2:0]  m_data;
  bit          m_v;
  int          reject_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Galois step written as shift-and-conditional-XOR on the whole word.
  function automatic logic [15:0] gstep(logic [15:0] x);
    logic msb = x[15];
    return ((x << 1) | 16'(msb)) ^ (msb ? (MASK & 16'hFFFE) : 16'h0);
  endfunction

  task automatic model_edge();
    int  c;
    bit  acc;
    if (reset_i) begin
      m_r = SEED; m_v = 0; m_data = 0;
    end else if (bus.seed_v_i) begin
      m_r = (zr && bus.seed_i == 0) ? SEED : bus.seed_i;
      m_v = 0;
    end else begin
      c   = int'(m_r) % 8;
      acc = (c < RANGE);
      if (!acc) reject_cnt++;
      if (!m_v || bus.ready_i) begin
        m_v = acc;
        if (acc) m_data = 3'(c);
      end
      m_r = (zr && m_r == 0) ? SEED : gstep(m_r);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_model(string tag);
    check({tag, ".v"}, 64'(bus.v_o), 64'(m_v));
    if (m_v) check({tag, ".data"}, 64'(bus.data_o), 64'(m_data));
    check({tag, ".r"}, 64'(dut.r_q), 64'(m_r));
  endtask

  typedef struct {
    string       name;
    bit          rst;
    bit          seed_v;
    logic [15:0] seed;
    bit          ready;
    bit          exp_v;
    bit          chk_data;
    logic [2:0]  exp_data;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [2:0]  hold;
    logic [15:0] r_start, r_exp;
    int          empty_cnt, rej0;
    bit          seen[RANGE];

    reset_i = 1; bus.seed_v_i = 0; bus.seed_i = 0; bus.ready_i = 0;

    // Reset, first value, reseed-with-reject, and reset-beats-reseed.
    vecs[0] = '{"reset",        1, 0, 16'h0000, 0, 0, 0, 3'd0, 16'd38};
    vecs[1] = '{"first_value",  0, 0, 16'h0000, 0, 1, 1, 3'd6, 16'd76};
    vecs[2] = '{"reseed7",      0, 1, 16'h0007, 1, 0, 0, 3'd0, 16'd7};
    vecs[3] = '{"reject7",      0, 0, 16'h0000, 1, 0, 0, 3'd0, 16'd14};
    vecs[4] = '{"accept6",      0, 0, 16'h0000, 1, 1, 1, 3'd6, 16'd28};
    vecs[5] = '{"accept4",      0, 0, 16'h0000, 1, 1, 1, 3'd4, 16'd56};
    vecs[6] = '{"rst_over_seed",1, 1, 16'h1234, 1, 0, 0, 3'd0, 16'd38};
    vecs[7] = '{"after_rst",    0, 0, 16'h0000, 1, 1, 1, 3'd6, 16'd76};

    @(posedge clk_i); #1;
    for (int i = 0; i < 8; i++) begin
      reset_i = vecs[i].rst; bus.seed_v_i = vecs[i].seed_v;
      bus.seed_i = vecs[i].seed; bus.ready_i = vecs[i].ready;
      tick();
      check({vecs[i].name, ".v"}, 64'(bus.v_o), 64'(vecs[i].exp_v));
      if (vecs[i].chk_data)
        check({vecs[i].name, ".data"}, 64'(bus.data_o), 64'(vecs[i].exp_data));
      check({vecs[i].name, ".r"}, 64'(dut.r_q), 64'(vecs[i].exp_r));
    end
    reset_i = 0; bus.seed_v_i = 0;

    // Backpressure: value held for 10 cycles while the LFSR keeps running.
    bus.ready_i = 0;
    hold = m_data;
    r_start = m_r;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold.v", 64'(bus.v_o), 64'd1);
      check("hold.data", 64'(bus.data_o), 64'(hold));
    end
    r_exp = r_start;
    for (int i = 0; i < 10; i++) r_exp = gstep(r_exp);
    check("hold.r_10_steps", 64'(dut.r_q), 64'(r_exp));

    // Sustained ready: range, empty cycles versus rejected candidates, coverage.
    bus.ready_i = 1;
    empty_cnt = 0;
    rej0 = reject_cnt;
    for (int i = 0; i < RANGE; i++) seen[i] = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!bus.v_o) empty_cnt++;
      else begin
        if (bus.data_o >= RANGE) check("stream.in_range", 64'(bus.data_o), 64'(m_data));
        else seen[bus.data_o] = 1;
      end
      if (i % 50 == 0) check_model("stream");
    end
    check("stream.empty_vs_rejects", 64'(empty_cnt), 64'(reject_cnt - rej0));
    for (int i = 0; i < RANGE; i++) check($sformatf("stream.seen_%0d", i), 64'(seen[i]), 64'd1);
    check_model("stream_end");

    // Random ready and occasional nonzero reseeds against the model.
    for (int i = 0; i < 600; i++) begin
      bus.ready_i  = $urandom_range(0, 1);
      bus.seed_v_i = ($urandom_range(0, 31) == 0);
      bus.seed_i   = 16'($urandom) | 16'h0001;
      tick();
      check_model("rand");
    end
    bus.seed_v_i = 0;

    // Reseed with zero.
    bus.ready_i = 1; bus.seed_v_i = 1; bus.seed_i = 16'h0000;
    tick();
    bus.seed_v_i = 0;
    check("zero.v_after_reseed", 64'(bus.v_o), 64'd0);
    check("zero.r_after_reseed", 64'(dut.r_q), zr ? 64'd38 : 64'd0);
    tick();
    check("zero.v_next", 64'(bus.v_o), 64'd1);
    check("zero.data_next", 64'(bus.data_o), zr ? 64'd6 : 64'd0);
    for (int i = 0; i < 20; i++) begin
      bus.ready_i = $urandom_range(0, 1);
      tick();
      check_model("zero_run");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
